i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

Parametrised I2C slave front-end with an internal byte-wide register file, register-pointer auto-increment, multi-byte burst reads and writes, and a local host port. It sits between the board-level SCL/SDA pins and on-chip logic. It generalises the fixed-address, single-byte echo slave to a configurable-address, NUM_REGS-deep register target. The whole block is synchronous to CLCK, except the asynchronous reset.

## Interface
- SLAVE_ADDR, 7'b1110010: 7-bit bus address the block responds to.
- NUM_REGS, 16: register file depth in bytes, 2..256.
- PTR_W, $clog2(NUM_REGS): pointer width (derived, not overridden).
- CLCK  in  1  system clock; must be ≥ 10× SCL frequency.
- RST  in  1  asynchronous, active-high reset.
- SCL  in  1  I2C clock from master.
- SDA  inout  1  I2C data; open-drain: driven 0 or released to 'z, never driven 1.
- loc_wr_en  in  1  local write strobe.
- loc_addr  in  PTR_W  local register index, for both write and read.
- loc_wr_data  in  8  local write data.
- loc_rd_data  out  8  combinational read of reg[loc_addr].
- wr_strobe  out  1  one-cycle pulse when an I2C write commits a byte.
- wr_reg  out  PTR_W  register index of that committed byte.
- wr_data  out  8  byte committed.
- busy  out  1  high from address match until STOP or a non-matching repeated START.

## Operation
- **Input synchronisation:** SCL and SDA each pass through a 3-flop shift register. Edges and levels are decoded from stages [2:1].
- **START:** SDA falls while SCL is high. Valid in any state, including mid-byte, which makes it a repeated START. It clears the bit counter and enters ADDR.
- **STOP:** SDA rises while SCL is high. From any state it goes to IDLE, releases SDA and drops busy.
- **Sampling and drive edges:** bits are sampled on the SCL rising edge, MSB first. The block changes SDA only on the SCL falling edge.
- **States:**
  - IDLE
  - ADDR (8 bits: 7-bit address plus R/W)
  - ADDR_ACK
  - PTR (8 bits)
  - PTR_ACK
  - WDATA (8 bits)
  - WDATA_ACK
  - RDATA (8 bits driven)
  - RDATA_ACK (sample master's ACK)
- **ADDR:** on a match the block ACKs and asserts busy. With R/W=0 it goes ADDR_ACK→PTR; with R/W=1 it goes ADDR_ACK→RDATA. On a mismatch it goes to IDLE with no ACK and SDA released.
- **PTR:**
  - A received value < NUM_REGS loads ptr and is ACKed, then PTR_ACK→WDATA.
  - A value ≥ NUM_REGS is NACKed, ptr is unchanged, and the state goes to IDLE.
- **WDATA:** on the 8th bit, reg[ptr] ← byte and wr_strobe pulses with wr_reg=ptr and wr_data=byte. Then the block ACKs and sets ptr ← (ptr+1) mod NUM_REGS.
- **RDATA:** the shift register loads reg[ptr] at the SCL falling edge that enters RDATA, and bits are driven MSB first. On the falling edge after bit 0, SDA is released and ptr increments mod NUM_REGS.
  - Master ACK (SDA=0) → next RDATA byte.
  - Master NACK → IDLE.
- **Read pointer:** a read without a preceding PTR uses the pointer left by the last transaction, which is 0 after reset.
- **Collision:** if loc_wr_en and an I2C commit target the same register in the same cycle, the I2C write wins and the local write is dropped. If they target different registers, both commit.
- **Reset state:** all registers 0, ptr 0, state IDLE, SDA released ('z), busy 0, wr_strobe 0, wr_reg 0, wr_data 0. loc_rd_data reflects reg[loc_addr], which is 0.
- **Reset mid-transfer:** the block releases SDA immediately (asynchronously) and ignores the bus until the next START.

## Timing
- **Synchroniser latency:** 2 CLCK cycles from pin to stage 1. Edge detection fires in the 3rd cycle.
- **ACK/data drive:** SDA is driven within 3 CLCK cycles after the physical SCL falling edge. It is held until the next detected SCL falling edge.
- **wr_strobe:** asserted exactly 1 CLCK cycle. It occurs in the cycle after the 8th data bit's SCL rising edge is detected.
- **busy:** rises with the SCL falling edge that begins ADDR_ACK. It falls the cycle after STOP is detected.
- **Local port:** a loc_wr_en write is visible on loc_rd_data the next cycle. A local write lands before an I2C read byte only if it precedes the load edge.
- **No clock stretching:** SCL is never held low.

## Test plan
- **Pointer write plus burst write:** START, 0xE4 (addr 0x72, W), 0x03, 0xA5, 0x5A, STOP.
  - ACK on all four bytes.
  - reg[3]=0xA5 and reg[4]=0x5A.
  - Two wr_strobe pulses with wr_reg 3 then 4.
  - busy drops after STOP.
- **Repeated-START read:** START, 0xE4, 0x03, rSTART, 0xE5, read 2 bytes (ACK, then NACK), STOP.
  - SDA carries 0xA5 then 0x5A.
  - ptr ends at 5.
- **Wrap-around:** with NUM_REGS=16, write pointer 0x0F, then data 0x11, 0x22.
  - reg[15]=0x11 and reg[0]=0x22.
- **Address mismatch:** START, 0xE6, 0x00.
  - SDA never driven and no wr_strobe.
  - busy stays 0.
- **Out-of-range pointer and collision:**
  - Pointer 0x10 with NUM_REGS=16 → NACK, and following bytes are ignored.
  - loc_wr_en to reg[2]=0x77 in the same cycle as an I2C commit of 0x99 to reg[2] → reg[2]=0x99.
- **Mid-read reset:** RST asserted during RDATA bit 4.
  - SDA released in the same cycle.
  - All outputs at reset values.
  - The next full transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a NUM_REGS-deep byte register file, auto-incrementing
// register pointer, burst reads/writes and a local host access port.
// SCL/SDA are oversampled on CLCK; SDA is open-drain (0 or released).
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1110010,
  parameter int         NUM_REGS   = 16,
  parameter int         PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             CLCK,
  input  logic             RST,
  input  logic             SCL,
  inout  wire              SDA,
  input  logic             loc_wr_en,
  input  logic [PTR_W-1:0] loc_addr,
  input  logic [7:0]       loc_wr_data,
  output logic [7:0]       loc_rd_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_reg,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  localparam logic [8:0]       NREGS9  = 9'(NUM_REGS);
  localparam logic [PTR_W:0]   NREGS_P = (PTR_W+1)'(NUM_REGS);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REGS - 1);

  state_t           state, state_n;
  logic [2:0]       scl_sync, sda_sync;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic             rw, rw_n, m_ack, m_ack_n, sda_drv, sda_drv_n, busy_n;
  logic             commit;
  logic [7:0]       regs [NUM_REGS];

  // Decoded bus events from the two settled synchroniser stages.
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [7:0] byte_in, rd_byte;
  logic loc_in_range;

  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign start_det = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
  assign stop_det  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];
  assign byte_in   = {shreg[6:0], sda_s};
  assign rd_byte   = regs[ptr];
  assign ptr_inc   = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;

  assign loc_in_range = ({1'b0, loc_addr} < NREGS_P);
  assign loc_rd_data  = loc_in_range ? regs[loc_addr] : 8'h00;

  // Reset gates the driver directly so SDA lets go without waiting for a clock.
  assign SDA = (sda_drv && !RST) ? 1'b0 : 1'bz;

  // Pin synchronisers; reset to the idle-bus level so no edge is seen.
  always_ff @(posedge CLCK or posedge RST) begin
    if (RST) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], SCL};
      sda_sync <= {sda_sync[1:0], SDA};
    end
  end

  // State register.
  always_ff @(posedge CLCK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath controls; START/STOP override any bit activity.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rw_n      = rw;
    m_ack_n   = m_ack;
    sda_drv_n = sda_drv;
    busy_n    = busy;
    commit    = 1'b0;
    if (stop_det) begin
      state_n   = S_IDLE;
      sda_drv_n = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
    end else if (start_det) begin
      state_n   = S_ADDR;
      sda_drv_n = 1'b0;
      bit_cnt_n = '0;
    end else begin
      case (state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == S_ADDR) begin
                if (byte_in[7:1] != SLAVE_ADDR) begin
                  state_n = S_IDLE;
                  busy_n  = 1'b0;
                end else begin
                  rw_n = byte_in[0];
                end
              end else if (state == S_PTR) begin
                if ({1'b0, byte_in} < NREGS9) ptr_n = byte_in[PTR_W-1:0];
                else                          state_n = S_IDLE;
              end else begin
                commit = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            // Byte accepted: drive ACK through the ninth clock.
            sda_drv_n = 1'b1;
            bit_cnt_n = '0;
            if (state == S_ADDR) begin
              state_n = S_ADDR_ACK;
              busy_n  = 1'b1;
            end else if (state == S_PTR) begin
              state_n = S_PTR_ACK;
            end else begin
              state_n = S_WDATA_ACK;
              ptr_n   = ptr_inc;
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            sda_drv_n = 1'b0;
            bit_cnt_n = '0;
            if (state == S_ADDR_ACK && rw) begin
              state_n   = S_RDATA;
              shreg_n   = rd_byte;
              sda_drv_n = ~rd_byte[7];
            end else if (state == S_ADDR_ACK) begin
              state_n = S_PTR;
            end else begin
              state_n = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              state_n   = S_RDATA_ACK;
              sda_drv_n = 1'b0;
              ptr_n     = ptr_inc;
            end else begin
              shreg_n   = {shreg[6:0], 1'b0};
              sda_drv_n = ~shreg[6];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) m_ack_n = ~sda_s;
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (m_ack) begin
              state_n   = S_RDATA;
              shreg_n   = rd_byte;
              sda_drv_n = ~rd_byte[7];
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers and register file; an I2C commit overrides a local write to the same index.
  always_ff @(posedge CLCK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      m_ack     <= 1'b0;
      sda_drv   <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
    end else begin
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      m_ack     <= m_ack_n;
      sda_drv   <= sda_drv_n;
      busy      <= busy_n;
      wr_strobe <= commit;
      if (commit) begin
        wr_reg  <= ptr;
        wr_data <= byte_in;
      end
      if (loc_wr_en && loc_in_range) regs[loc_addr] <= loc_wr_data;
      if (commit) regs[ptr] <= byte_in;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master, local port
// stimulus and monitors for write strobes, slave SDA drive and busy.
module tb_i2c_slave_regfile;
  localparam int Q = 5;  // quarter SCL period in CLCK cycles

  logic       clk = 1'b0;
  logic       rst, scl, m_low, loc_wr_en;
  logic [3:0] loc_addr;
  logic [7:0] loc_wr_data;
  wire  [7:0] loc_rd_data;
  wire        wr_strobe;
  wire  [3:0] wr_reg;
  wire  [7:0] wr_data;
  wire        busy;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regfile dut (
    .CLCK(clk), .RST(rst), .SCL(scl), .SDA(sda),
    .loc_wr_en(loc_wr_en), .loc_addr(loc_addr), .loc_wr_data(loc_wr_data),
    .loc_rd_data(loc_rd_data), .wr_strobe(wr_strobe), .wr_reg(wr_reg),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int strobe_cnt = 0, strobe_long = 0, dut_low_cnt = 0, busy_cnt = 0;
  logic [3:0] log_reg [64];
  logic [7:0] log_data [64];
  logic prev_strobe = 1'b0;

  // Monitor sampled mid-low-phase of CLCK, away from both edges.
  always begin
    @(negedge clk);
    #1;
    if (wr_strobe) begin
      if (strobe_cnt < 64) begin
        log_reg[strobe_cnt]  = wr_reg;
        log_data[strobe_cnt] = wr_data;
      end
      strobe_cnt++;
    end
    if (wr_strobe && prev_strobe) strobe_long++;
    prev_strobe = wr_strobe;
    if (sda === 1'b0 && !m_low) dut_low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_loc(input logic [3:0] a, output logic [7:0] d);
    loc_addr = a;
    #1;
    d = loc_rd_data;
  endtask

  task automatic wr_loc(input logic [3:0] a, input logic [7:0] d);
    loc_addr = a; loc_wr_data = d; loc_wr_en = 1'b1;
    cyc(1);
    loc_wr_en = 1'b0;
  endtask

  // One SCL clock; optionally fires a local write in the cycle the slave commits.
  task automatic i2c_bit(input logic b, input logic coll, input logic [3:0] ca,
                         input logic [7:0] cd, output logic s);
    cyc(Q); m_low = ~b;
    cyc(Q); scl = 1'b1;
    if (coll) begin
      cyc(2); loc_addr = ca; loc_wr_data = cd; loc_wr_en = 1'b1;
      cyc(1); loc_wr_en = 1'b0;
      cyc(Q - 3);
    end else begin
      cyc(Q);
    end
    s = sda;
    cyc(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    cyc(Q); m_low = 1'b0;
    cyc(Q); scl = 1'b1;
    cyc(Q); m_low = 1'b1;
    cyc(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(Q); m_low = 1'b1;
    cyc(Q); scl = 1'b1;
    cyc(Q); m_low = 1'b0;
    cyc(Q);
  endtask

  // Returns the ninth-bit level: 0 = ACK, 1 = NACK.
  task automatic send_c(input logic [7:0] d, input logic coll, input logic [3:0] ca,
                        input logic [7:0] cd, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], coll && (i == 0), ca, cd, s);
    i2c_bit(1'b1, 1'b0, 4'h0, 8'h00, nack);
  endtask

  task automatic send(input logic [7:0] d, output logic nack);
    send_c(d, 1'b0, 4'h0, 8'h00, nack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 1'b0, 4'h0, 8'h00, s);
      d[i] = s;
    end
    i2c_bit(nack, 1'b0, 4'h0, 8'h00, s);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int s0, l0, b0;
    rst = 1'b1; scl = 1'b1; m_low = 1'b0;
    loc_wr_en = 1'b0; loc_addr = 4'h5; loc_wr_data = 8'h00;
    cyc(3);
    #1;
    chk("rst_sda", 32'(sda), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strobe", 32'(wr_strobe), 32'h0);
    chk("rst_wr_reg", 32'(wr_reg), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_loc_rd", 32'(loc_rd_data), 32'h0);
    cyc(1); rst = 1'b0;
    cyc(5);

    // Pointer write then two-byte burst write.
    s0 = strobe_cnt;
    i2c_start();
    send(8'hE4, a); chk("t1_addr_ack", 32'(a), 32'h0);
    chk("t1_busy_hi", 32'(busy), 32'h1);
    send(8'h03, a); chk("t1_ptr_ack", 32'(a), 32'h0);
    send(8'hA5, a); chk("t1_d0_ack", 32'(a), 32'h0);
    send(8'h5A, a); chk("t1_d1_ack", 32'(a), 32'h0);
    i2c_stop();
    cyc(4);
    chk("t1_busy_lo", 32'(busy), 32'h0);
    rd_loc(4'h3, d); chk("t1_reg3", 32'(d), 32'hA5);
    rd_loc(4'h4, d); chk("t1_reg4", 32'(d), 32'h5A);
    chk("t1_strobes", 32'(strobe_cnt - s0), 32'h2);
    chk("t1_wr_reg0", 32'(log_reg[s0]), 32'h3);
    chk("t1_wr_dat0", 32'(log_data[s0]), 32'hA5);
    chk("t1_wr_reg1", 32'(log_reg[s0+1]), 32'h4);
    chk("t1_wr_dat1", 32'(log_data[s0+1]), 32'h5A);

    // Local write visible next cycle; then repeated-START burst read.
    wr_loc(4'h5, 8'hC3);
    rd_loc(4'h5, d); chk("loc_wr_vis", 32'(d), 32'hC3);
    i2c_start();
    send(8'hE4, a);
    send(8'h03, a);
    i2c_start();
    send(8'hE5, a); chk("t2_rd_ack", 32'(a), 32'h0);
    read_byte(1'b0, d); chk("t2_rd0", 32'(d), 32'hA5);
    read_byte(1'b1, d); chk("t2_rd1", 32'(d), 32'h5A);
    i2c_stop();
    // Read with no pointer phase continues from ptr 5.
    i2c_start();
    send(8'hE5, a);
    read_byte(1'b1, d); chk("t2_ptr5", 32'(d), 32'hC3);
    i2c_stop();

    // Pointer wrap-around.
    i2c_start();
    send(8'hE4, a);
    send(8'h0F, a); chk("t3_ptr_ack", 32'(a), 32'h0);
    send(8'h11, a);
    send(8'h22, a); chk("t3_d1_ack", 32'(a), 32'h0);
    i2c_stop();
    rd_loc(4'hF, d); chk("t3_reg15", 32'(d), 32'h11);
    rd_loc(4'h0, d); chk("t3_reg0", 32'(d), 32'h22);

    // Address mismatch: slave stays silent.
    s0 = strobe_cnt; l0 = dut_low_cnt; b0 = busy_cnt;
    i2c_start();
    send(8'hE6, a); chk("t4_addr_nack", 32'(a), 32'h1);
    send(8'h00, a); chk("t4_data_nack", 32'(a), 32'h1);
    i2c_stop();
    chk("t4_no_drive", 32'(dut_low_cnt - l0), 32'h0);
    chk("t4_no_busy", 32'(busy_cnt - b0), 32'h0);
    chk("t4_no_strobe", 32'(strobe_cnt - s0), 32'h0);

    // Out-of-range pointer: NACK, later bytes ignored, ptr kept at 1.
    wr_loc(4'h1, 8'h4D);
    i2c_start();
    send(8'hE4, a);
    send(8'h10, a); chk("t5_ptr_nack", 32'(a), 32'h1);
    s0 = strobe_cnt; l0 = dut_low_cnt;
    send(8'h55, a); chk("t5_data_nack", 32'(a), 32'h1);
    i2c_stop();
    chk("t5_no_drive", 32'(dut_low_cnt - l0), 32'h0);
    chk("t5_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    i2c_start();
    send(8'hE5, a);
    read_byte(1'b1, d); chk("t5_ptr_kept", 32'(d), 32'h4D);
    i2c_stop();

    // Collisions: same register (I2C wins) and a different register (both land).
    i2c_start();
    send(8'hE4, a);
    send(8'h02, a);
    send_c(8'h99, 1'b1, 4'h2, 8'h77, a); chk("t5_coll_ack", 32'(a), 32'h0);
    send_c(8'hAB, 1'b1, 4'h9, 8'h66, a);
    i2c_stop();
    rd_loc(4'h2, d); chk("t5_coll_same", 32'(d), 32'h99);
    rd_loc(4'h3, d); chk("t5_coll_i2c", 32'(d), 32'hAB);
    rd_loc(4'h9, d); chk("t5_coll_loc", 32'(d), 32'h66);

    // Reset while the slave drives bit 4 (a 0) of a read byte from reg[4]=0xE7.
    wr_loc(4'h4, 8'hE7);
    i2c_start();
    send(8'hE5, a); chk("t6_rd_ack", 32'(a), 32'h0);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, 1'b0, 4'h0, 8'h00, a);
    cyc(Q);
    chk("t6_bit4_drv", 32'(sda), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("t6_sda_rel", 32'(sda), 32'h1);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_strobe", 32'(wr_strobe), 32'h0);
    chk("t6_wr_reg", 32'(wr_reg), 32'h0);
    chk("t6_wr_data", 32'(wr_data), 32'h0);
    rd_loc(4'h4, d); chk("t6_reg4_clr", 32'(d), 32'h00);
    cyc(2); rst = 1'b0;
    cyc(3);
    s0 = strobe_cnt;
    i2c_start();
    send(8'hE4, a); chk("t6_re_addr_ack", 32'(a), 32'h0);
    send(8'h00, a);
    send(8'h3C, a); chk("t6_re_data_ack", 32'(a), 32'h0);
    i2c_stop();
    chk("t6_re_strobe", 32'(strobe_cnt - s0), 32'h1);
    chk("t6_re_wr_data", 32'(log_data[s0]), 32'h3C);
    i2c_start();
    send(8'hE4, a);
    send(8'h00, a);
    i2c_start();
    send(8'hE5, a);
    read_byte(1'b1, d); chk("t6_re_read", 32'(d), 32'h3C);
    i2c_stop();

    chk("strobe_width", 32'(strobe_long), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
